// File: rtl/seqdet_pkg.sv
// Shared state encodings and default sizing for the programmable Mealy serial pattern detector.
package seqdet_pkg;

  localparam int PAT_W_DEF = 5;
  localparam int CNT_W_DEF = 8;
  localparam int LEN_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } seq_state_e;

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_DONE = ST_DONE;

endpackage

// File: rtl/seqdet_match_core.sv
// History/fill tracking and length-masked compare; match_o is combinational on accept_i/x_i.
// Non-overlapping unless SEQDET_OVERLAP_EN is defined (then history is kept across a match).
module seqdet_match_core
  import seqdet_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int PL_W  = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             accept_i,
  input  logic             x_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [PL_W-1:0]  pat_len_i,
  output logic             match_o
);

  // Only PAT_W-1 past bits are needed: with the live bit they form a full-length window.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [PL_W-1:0]  fill_q, fill_d;
  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] len_mask;
  logic             fill_ok;
  logic             bits_eq;

  assign window = {hist_q, x_i};

  always_comb begin
    len_mask = '0;
    for (int k = 0; k < PAT_W; k++) begin
      len_mask[k] = (PL_W'(k) < pat_len_i);
    end
  end

  assign fill_ok = ({1'b0, fill_q} + (PL_W+1)'(1)) >= {1'b0, pat_len_i};
  assign bits_eq = ((window ^ pattern_i) & len_mask) == '0;
  assign match_o = accept_i & fill_ok & bits_eq;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (accept_i) begin
      hist_d = window[PAT_W-2:0];
      fill_d = (fill_q == PL_W'(PAT_W)) ? fill_q : fill_q + PL_W'(1);
`ifndef SEQDET_OVERLAP_EN
      if (match_o) begin
        fill_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seqdet_run_ctrl.sv
// Run controller: start/abort FSM, config shadow, bit/match counters; z is same-cycle Mealy.
// in_ready is high only in RUN (one cycle after start); SEQDET_OVERLAP_EN selects overlapping matches.
module seqdet_run_ctrl
  import seqdet_pkg::*;
#(
  parameter  int PAT_W = PAT_W_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  parameter  int LEN_W = LEN_W_DEF,
  localparam int PL_W  = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PL_W-1:0]  cfg_pat_len,
  input  logic [LEN_W-1:0] cfg_run_len,
  input  logic             x,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             z,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       state
);

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PL_W-1:0]  plen_q, plen_d;
  logic [LEN_W-1:0] rlen_q, rlen_d;
  logic [LEN_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic cfg_ok;
  logic accept;
  logic clr;
  logic last_bit;
  logic match_raw;

  assign cfg_ok   = (cfg_pat_len != '0) && (cfg_pat_len <= PL_W'(PAT_W)) && (cfg_run_len != '0);
  assign in_ready = (state_q == S_RUN);
  // abort wins over any same-cycle bit, so that bit is never consumed.
  assign accept   = in_ready & in_valid & ~abort;
  assign clr      = (state_q == S_IDLE) & start;
  assign last_bit = (bits_q + LEN_W'(1)) == rlen_q;

  seqdet_match_core #(
    .PAT_W (PAT_W),
    .PL_W  (PL_W)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (clr),
    .accept_i  (accept),
    .x_i       (x),
    .pattern_i (pat_q),
    .pat_len_i (plen_q),
    .match_o   (match_raw)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    plen_d  = plen_q;
    rlen_d  = rlen_q;
    bits_d  = bits_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d  = cfg_pattern;
          plen_d = cfg_pat_len;
          rlen_d = cfg_run_len;
          bits_d = '0;
          cnt_d  = '0;
          if (cfg_ok) begin
            err_d   = 1'b0;
            state_d = S_RUN;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (accept) begin
          bits_d = bits_q + LEN_W'(1);
          if (match_raw && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (last_bit) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      plen_q  <= '0;
      rlen_q  <= '0;
      bits_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      plen_q  <= plen_d;
      rlen_q  <= rlen_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign z           = match_raw;
  assign match_count = cnt_q;
  assign busy        = in_ready;
  assign done        = (state_q == S_DONE);
  assign err         = err_q;
  assign state       = state_q;

  a_done_one_cycle : assert property (@(posedge clk) disable iff (reset)
    (state_q == S_DONE) |=> (state_q == S_IDLE));
  a_z_only_when_ready : assert property (@(posedge clk) disable iff (reset)
    z |-> in_ready);

endmodule

// File: tb/tb_seqdet_run_ctrl.sv
// Bench for seqdet_run_ctrl: directed scenarios plus randomized runs against a bit-queue reference model.
module tb_seqdet_run_ctrl;

  localparam int PAT_W   = 5;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = 16;
  localparam int PL_W    = $clog2(PAT_W + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int SAT_MAX = 3;

  logic             clk = 1'b0;
  logic             reset, start, abort, x, in_valid;
  logic [PAT_W-1:0] cfg_pattern;
  logic [PL_W-1:0]  cfg_pat_len;
  logic [LEN_W-1:0] cfg_run_len;

  logic             in_ready, z, busy, done, err;
  logic [CNT_W-1:0] match_count;
  logic [1:0]       state;

  logic             s_in_ready, s_z, s_busy, s_done, s_err;
  logic [1:0]       s_match_count;
  logic [1:0]       s_state;

  int errors = 0;
  int checks = 0;

  // Reference model: received bits since start (or since the last match when non-overlapping).
  logic             mq[$];
  logic [PAT_W-1:0] m_pat;
  int               m_len;
  int               m_cnt;
  int               m_sat;

  always #5 clk = ~clk;

  seqdet_run_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_pattern(cfg_pattern), .cfg_pat_len(cfg_pat_len), .cfg_run_len(cfg_run_len),
    .x(x), .in_valid(in_valid), .in_ready(in_ready), .z(z), .match_count(match_count),
    .busy(busy), .done(done), .err(err), .state(state)
  );

  seqdet_run_ctrl #(.PAT_W(PAT_W), .CNT_W(2), .LEN_W(LEN_W)) u_sat (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_pattern(cfg_pattern), .cfg_pat_len(cfg_pat_len), .cfg_run_len(cfg_run_len),
    .x(x), .in_valid(in_valid), .in_ready(s_in_ready), .z(s_z), .match_count(s_match_count),
    .busy(s_busy), .done(s_done), .err(s_err), .state(s_state)
  );

  function automatic logic model_accept(input logic b);
    logic hit;
    hit = 1'b1;
    mq.push_back(b);
    if (mq.size() < m_len) begin
      hit = 1'b0;
    end else begin
      for (int k = 0; k < m_len; k++) begin
        if (mq[mq.size() - 1 - k] !== m_pat[k]) hit = 1'b0;
      end
    end
    if (hit) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      if (m_sat < SAT_MAX) m_sat++;
`ifndef SEQDET_OVERLAP_EN
      mq.delete();
`endif
    end
    return hit;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [PAT_W-1:0] pat, input int len, input int run);
    start       = 1'b1;
    cfg_pattern = pat;
    cfg_pat_len = PL_W'(len);
    cfg_run_len = LEN_W'(run);
    m_pat = pat; m_len = len; m_cnt = 0; m_sat = 0;
    mq.delete();
    next_cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; x = 1'b1; in_valid = 1'b1;
    cfg_pattern = '0; cfg_pat_len = '0; cfg_run_len = '0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (match_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", match_count); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL reset_z_idle: got %b want 0", z); end
    in_valid = 1'b0;
  endtask

  task automatic test_stream(input int gap);
    logic [6:0] stream;
    logic       expz;
    int         exp_final;
    stream = 7'b1010101;
`ifdef SEQDET_OVERLAP_EN
    exp_final = 2;
`else
    exp_final = 1;
`endif
    in_valid = 1'b0;
    do_start(5'b10101, 5, 7);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL stream_run_state: got %0d want 1", state); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready: got %b want 1", in_ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL stream_err: got %b want 0", err); end
    for (int i = 0; i < 7; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0; x = 1'($urandom);
        #1;
        checks++; if (z !== 1'b0) begin errors++; $display("FAIL stream_gap_z: bit %0d got %b want 0", i + 1, z); end
        next_cycle();
        checks++; if (match_count !== CNT_W'(m_cnt)) begin errors++; $display("FAIL stream_gap_count: got %0d want %0d", match_count, m_cnt); end
      end
      in_valid = 1'b1; x = stream[6 - i];
      #1;
      expz = model_accept(x);
      checks++; if (z !== expz) begin errors++; $display("FAIL stream_z: bit %0d gap %0d got %b want %b", i + 1, gap, z, expz); end
      next_cycle();
      checks++; if (match_count !== CNT_W'(m_cnt)) begin errors++; $display("FAIL stream_count: bit %0d got %0d want %0d", i + 1, match_count, m_cnt); end
    end
    in_valid = 1'b0;
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stream_done: got %b want 1", done); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL stream_done_state: got %0d want 2", state); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stream_done_ready: got %b want 0", in_ready); end
    checks++; if (match_count !== CNT_W'(exp_final)) begin errors++; $display("FAIL stream_final_count: got %0d want %0d", match_count, exp_final); end
    next_cycle();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stream_done_pulse: got %b want 0", done); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL stream_idle: got %0d want 0", state); end
    checks++; if (match_count !== CNT_W'(exp_final)) begin errors++; $display("FAIL stream_hold_count: got %0d want %0d", match_count, exp_final); end
  endtask

  task automatic test_invalid_cfg();
    for (int t = 0; t < 3; t++) begin
      int len;
      int run;
      case (t)
        0:       begin len = 0;         run = 7; end
        1:       begin len = PAT_W + 1; run = 7; end
        default: begin len = 3;         run = 0; end
      endcase
      in_valid = 1'b1; x = 1'b1;
      do_start(5'b10101, len, run);
      checks++; if (state !== 2'b10) begin errors++; $display("FAIL invalid_state: cfg %0d got %0d want 2", t, state); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL invalid_err: cfg %0d got %b want 1", t, err); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL invalid_done: cfg %0d got %b want 1", t, done); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL invalid_ready: cfg %0d got %b want 0", t, in_ready); end
      checks++; if (match_count !== '0) begin errors++; $display("FAIL invalid_count: cfg %0d got %0d want 0", t, match_count); end
      next_cycle();
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL invalid_idle: cfg %0d got %0d want 0", t, state); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL invalid_done_pulse: cfg %0d got %b want 0", t, done); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL invalid_err_hold: cfg %0d got %b want 1", t, err); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL invalid_ready_idle: cfg %0d got %b want 0", t, in_ready); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_abort();
    logic [2:0] bits;
    logic       expz;
    bits = 3'b110;
    in_valid = 1'b0;
    do_start(5'b00011, 2, 10);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_err_cleared: got %b want 0", err); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; x = bits[2 - i];
      #1;
      expz = model_accept(x);
      checks++; if (z !== expz) begin errors++; $display("FAIL abort_pre_z: bit %0d got %b want %b", i + 1, z, expz); end
      next_cycle();
    end
    abort = 1'b1; in_valid = 1'b1; x = 1'b1;
    #1;
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL abort_z: got %b want 0", z); end
    next_cycle();
    abort = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL abort_state: got %0d want 0", state); end
    checks++; if (match_count !== CNT_W'(1)) begin errors++; $display("FAIL abort_count: got %0d want 1", match_count); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", done); end
    next_cycle();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done_late: got %b want 0", done); end
  endtask

  task automatic test_saturation();
    logic expz;
    in_valid = 1'b0;
    do_start(5'b00001, 1, 6);
    checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL sat_busy: got %b want 1", s_busy); end
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; x = 1'b1;
      #1;
      expz = model_accept(1'b1);
      checks++; if (s_z !== expz) begin errors++; $display("FAIL sat_z: bit %0d got %b want %b", i + 1, s_z, expz); end
      checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL sat_ready: bit %0d got %b want 1", i + 1, s_in_ready); end
      next_cycle();
      checks++; if (s_match_count !== 2'(m_sat)) begin errors++; $display("FAIL sat_count: bit %0d got %0d want %0d", i + 1, s_match_count, m_sat); end
    end
    in_valid = 1'b0;
    #1;
    checks++; if (s_match_count !== 2'd3) begin errors++; $display("FAIL sat_final: got %0d want 3", s_match_count); end
    checks++; if (s_done !== 1'b1 || s_state !== 2'b10 || s_err !== 1'b0) begin
      errors++; $display("FAIL sat_done: done %b state %0d err %b want 1 2 0", s_done, s_state, s_err);
    end
    next_cycle();
    do_start(5'b00001, 1, 300);
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; x = 1'b1;
      #1;
      expz = model_accept(1'b1);
      next_cycle();
      checks++; if (match_count !== CNT_W'(m_cnt)) begin errors++; $display("FAIL sat8_count: bit %0d got %0d want %0d", i + 1, match_count, m_cnt); end
    end
    in_valid = 1'b0;
    #1;
    checks++; if (match_count !== CNT_W'(CNT_MAX) || done !== 1'b1) begin
      errors++; $display("FAIL sat8_final: count %0d done %b want %0d 1", match_count, done, CNT_MAX);
    end
    next_cycle();
  endtask

  task automatic test_reset_midrun();
    logic [2:0] pre;
    logic [4:0] seq;
    logic       expz;
    pre = 3'b101;
    seq = 5'b10110;
    in_valid = 1'b0;
    do_start(5'b10110, 5, 20);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; x = pre[2 - i];
      #1;
      expz = model_accept(x);
      next_cycle();
    end
    in_valid = 1'b0; reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL midrst_state: got %0d want 0", state); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL midrst_flags: ready %b busy %b done %b err %b want 0 0 0 0", in_ready, busy, done, err);
    end
    checks++; if (match_count !== '0) begin errors++; $display("FAIL midrst_count: got %0d want 0", match_count); end
    do_start(5'b10110, 5, 20);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; x = seq[4 - i];
      #1;
      expz = model_accept(x);
      checks++; if (z !== expz) begin errors++; $display("FAIL midrst_fresh_z: bit %0d got %b want %b", i + 1, z, expz); end
      next_cycle();
    end
    in_valid = 1'b0;
    checks++; if (match_count !== CNT_W'(1)) begin errors++; $display("FAIL midrst_fresh_count: got %0d want 1", match_count); end
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      int  len;
      int  run;
      int  nbits;
      bit  finished;
      bit  ab;
      logic expz;
      len = $urandom_range(1, PAT_W);
      run = $urandom_range(4, 40);
      nbits = 0;
      finished = 1'b0;
      in_valid = 1'b0;
      do_start(PAT_W'($urandom), len, run);
      for (int c = 0; c < 400 && !finished; c++) begin
        in_valid = ($urandom_range(0, 9) < 7);
        x = 1'($urandom);
        ab = ($urandom_range(0, 99) == 0);
        abort = ab;
        #1;
        expz = 1'b0;
        if (!ab && in_valid) begin
          expz = model_accept(x);
          nbits++;
        end
        checks++; if (z !== expz) begin errors++; $display("FAIL rand_z: run %0d cyc %0d got %b want %b", r, c, z, expz); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rand_ready: run %0d cyc %0d got %b want 1", r, c, in_ready); end
        next_cycle();
        abort = 1'b0;
        checks++; if (match_count !== CNT_W'(m_cnt)) begin errors++; $display("FAIL rand_count: run %0d cyc %0d got %0d want %0d", r, c, match_count, m_cnt); end
        if (ab) begin
          finished = 1'b1;
          checks++; if (state !== 2'b00 || done !== 1'b0) begin errors++; $display("FAIL rand_abort: state %0d done %b want 0 0", state, done); end
        end else if (nbits == run) begin
          finished = 1'b1;
          checks++; if (state !== 2'b10 || done !== 1'b1) begin errors++; $display("FAIL rand_done: state %0d done %b want 2 1", state, done); end
          next_cycle();
        end
      end
      in_valid = 1'b0;
      if (!finished) begin
        checks++; errors++;
        $display("FAIL rand_timeout: run %0d got no end after 400 cycles want end at bit %0d", r, run);
        reset = 1'b1; next_cycle(); reset = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream(0);
    test_stream(3);
    test_invalid_cfg();
    test_abort();
    test_saturation();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
